falafel_hdr_lsu: RTL and testbench
==================================

Name: falafel_hdr_lsu

Overview:
Parametrised next-generation load/store unit between the falafel allocator core and the memory port. It executes one free-list header operation per core request: lock, unlock, load, update, alloc-insert, free-insert or delete. Header word layout, lock address and lock ID are parametrised. Lock acquisition adds exponential backoff and a bounded retry count that ends in an error response. Exactly one memory transaction is outstanding at a time.

Parameters:
DATA_W, 64, width of data, address and header words
NEXT_ADDR_OFFSET, 8, byte offset of the next_addr word from the header base (size word is at offset 0)
LOCK_ADDR, 0, address of the allocator lock word
LOCK_ID, 1, value written by CAS to claim the lock; must differ from EMPTY_KEY
EMPTY_KEY, 0, lock word value meaning "free"
BACKOFF_MAX_LOG2, 4, cap on backoff exponent
MAX_LOCK_TRIES, 16, lock attempts before error; 0 = unlimited

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
core_req_val_i  in  1  core request valid
core_req_rdy_o  out  1  LSU accepts a request (high only in IDLE)
core_req_op_i  in  3  0 LOCK, 1 UNLOCK, 2 LOAD, 3 UPDATE, 4 ALLOC_INSERT, 5 FREE_INSERT, 6 DELETE
core_req_addr_i  in  DATA_W  header base address
core_req_size_i  in  DATA_W  size to store
core_req_next_addr_i  in  DATA_W  next_addr to store
core_rsp_val_o  out  1  response valid
core_rsp_rdy_i  in  1  core accepts response
core_rsp_addr_o  out  DATA_W  echo of request address
core_rsp_size_o  out  DATA_W  loaded size (LOAD only, else 0)
core_rsp_next_addr_o  out  DATA_W  loaded next_addr (LOAD only, else 0)
core_rsp_err_o  out  1  lock retry limit reached, or illegal op
mem_req_val_o  out  1  memory request valid
mem_req_rdy_i  in  1  memory ready
mem_req_is_write_o  out  1  1 store, 0 load
mem_req_is_cas_o  out  1  compare-and-swap
mem_req_addr_o  out  DATA_W  address
mem_req_data_o  out  DATA_W  store data / CAS new value
mem_req_cas_exp_o  out  DATA_W  CAS expected value
mem_rsp_val_i  in  1  memory response valid
mem_rsp_rdy_o  out  1  LSU accepts response
mem_rsp_data_i  in  DATA_W  load data / CAS old value

Behaviour:
- Reset (async, while rst_i high):
  - state IDLE; every output 0.
  - Request, response, try and backoff registers cleared.
  - Reset mid-transaction abandons it; no response is ever issued for that request.
- Request capture:
  - Handshake fires on core_req_val_i & core_req_rdy_o.
  - op, addr, size and next_addr are registered; response size, next_addr and err are cleared.
  - core_req_rdy_o is high only in IDLE.
- Memory request handshake:
  - mem_req_* held stable from val rise until mem_req_rdy_i.
  - Transfer happens on the val & rdy cycle; next state is WAIT.
  - In WAIT, mem_rsp_rdy_o = 1; mem_rsp_val_i is consumed on the same cycle.
  - mem_rsp_val_i outside WAIT is ignored and mem_rsp_rdy_o = 0.
- States: IDLE, LK_LOAD, LK_CAS, BACKOFF, ACC_SIZE, ACC_NEXT, WAIT, RSP.
- Op sequences:
  - LOCK: LK_LOAD reads LOCK_ADDR.
    - If data == EMPTY_KEY, go to LK_CAS: addr LOCK_ADDR, exp EMPTY_KEY, data LOCK_ID.
    - CAS old value == EMPTY_KEY means success, go to RSP with err = 0.
    - A busy load or a failed CAS is one failed try.
  - UNLOCK: single store of EMPTY_KEY to LOCK_ADDR, then RSP.
  - LOAD: load addr, then load addr+NEXT_ADDR_OFFSET; capture both words, then RSP.
  - UPDATE / ALLOC_INSERT: store size at addr, then store next_addr at addr+NEXT_ADDR_OFFSET, then RSP.
  - FREE_INSERT / DELETE: store next_addr at addr+NEXT_ADDR_OFFSET only, then RSP.
  - Op 7: go directly to RSP with err = 1; no memory access.
- Backoff:
  - tries counts failed attempts, with n = tries after increment.
  - If MAX_LOCK_TRIES != 0 and n == MAX_LOCK_TRIES, go to RSP with err = 1; the lock is not held.
  - Otherwise go to BACKOFF for exactly 2^min(n-1, BACKOFF_MAX_LOG2) cycles, then LK_LOAD.
  - tries resets to 0 on request accept.
- Response:
  - In RSP, core_rsp_val_o = 1 and fields are stable until core_rsp_rdy_i.
  - On that cycle, go to IDLE. Earliest new accept is the following cycle.
- Address arithmetic: addr + NEXT_ADDR_OFFSET is computed modulo 2^DATA_W (wraps).
- Latency at zero-wait memory and rsp_rdy:
  - LOAD: accept to rsp_val = 5 cycles.
  - UNLOCK: accept to rsp_val = 3 cycles.
  - Uncontended LOCK: accept to rsp_val = 5 cycles.

Decomposition:
- falafel_pkg holds:
  - op enum (falafel_lsu_op_e) with the encodings above;
  - EMPTY_KEY and block offset defaults;
  - state enum.
- Sub-module falafel_lock_backoff holds tries, backoff window computation and the countdown:
  - inputs start/fail;
  - outputs done and give_up.

Test Plan:
- LOAD addr 0x1000, mem returns 0x40 then 0x2000 -> loads at 0x1000 and 0x1008; rsp size 0x40, next 0x2000, err 0.
- UPDATE addr 0x1000 size 0x80 next 0x3000, mem_req_rdy low for 3 cycles each -> store 0x80@0x1000 then 0x3000@0x1008; outputs held stable while stalled.
- LOCK, lock word returns 1,1,0 then CAS old 0 -> backoff gaps of 1 and 2 cycles; CAS exp 0 data 1 @0x0; rsp err 0.
- LOCK with MAX_LOCK_TRIES=3, every lock load returns 1 -> exactly 3 lock loads, then rsp err 1.
- FREE_INSERT addr 0xFFFF_FFFF_FFFF_FFFC -> single store to 0x4 (wrapped); op 7 -> immediate err 1, no mem_req_val.
- rst_i asserted while in WAIT, then released -> all outputs 0, no core_rsp_val, next LOAD executes normally.

Source files
------------

// File: rtl/falafel_pkg.sv
`default_nettype none
// falafel_pkg: operation/state encodings and default header layout for the falafel header LSU.
package falafel_pkg;

  localparam int DEFAULT_DATA_W           = 64;
  localparam int DEFAULT_NEXT_ADDR_OFFSET = 8;
  localparam int DEFAULT_EMPTY_KEY        = 0;

  typedef enum logic [2:0] {
    OP_LOCK         = 3'd0,
    OP_UNLOCK       = 3'd1,
    OP_LOAD         = 3'd2,
    OP_UPDATE       = 3'd3,
    OP_ALLOC_INSERT = 3'd4,
    OP_FREE_INSERT  = 3'd5,
    OP_DELETE       = 3'd6,
    OP_ILLEGAL      = 3'd7
  } falafel_lsu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LK_LOAD  = 3'd1,
    ST_LK_CAS   = 3'd2,
    ST_BACKOFF  = 3'd3,
    ST_ACC_SIZE = 3'd4,
    ST_ACC_NEXT = 3'd5,
    ST_WAIT     = 3'd6,
    ST_RSP      = 3'd7
  } falafel_state_e;

  // First state entered after a request is accepted.
  function automatic falafel_state_e first_state(input falafel_lsu_op_e op);
    case (op)
      OP_LOCK:                                      first_state = ST_LK_LOAD;
      OP_UNLOCK, OP_LOAD, OP_UPDATE, OP_ALLOC_INSERT: first_state = ST_ACC_SIZE;
      OP_FREE_INSERT, OP_DELETE:                    first_state = ST_ACC_NEXT;
      default:                                      first_state = ST_RSP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/falafel_lock_backoff.sv
`default_nettype none
// falafel_lock_backoff: counts failed lock tries and times the exponential backoff window.
module falafel_lock_backoff
  import falafel_pkg::*;
#(
  parameter int BACKOFF_MAX_LOG2 = 4,
  parameter int MAX_LOCK_TRIES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic fail,
  output logic done,
  output logic give_up
);

  localparam int CNT_W = BACKOFF_MAX_LOG2 + 1;

  logic [31:0]      tries;
  logic [31:0]      tries_next;
  logic [31:0]      expo;
  logic [CNT_W-1:0] window;
  logic [CNT_W-1:0] count;

  always_comb begin
    // Saturate so the unlimited-retry case never wraps back to a short window.
    tries_next = (tries == '1) ? tries : tries + 32'd1;
    expo       = tries_next - 32'd1;
    if (expo > 32'(BACKOFF_MAX_LOG2)) begin
      expo = 32'(BACKOFF_MAX_LOG2);
    end
    window  = CNT_W'(1) << expo;
    give_up = fail && (MAX_LOCK_TRIES != 0) && (tries_next == 32'(MAX_LOCK_TRIES));
    done    = (count == CNT_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tries <= '0;
      count <= '0;
    end else if (start) begin
      tries <= '0;
      count <= '0;
    end else if (fail) begin
      tries <= tries_next;
      count <= give_up ? '0 : window;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/falafel_hdr_lsu.sv
`default_nettype none
// falafel_hdr_lsu: executes one free-list header operation per core request,
// keeping exactly one memory transaction outstanding.
module falafel_hdr_lsu
  import falafel_pkg::*;
#(
  parameter int                DATA_W           = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] NEXT_ADDR_OFFSET = DATA_W'(DEFAULT_NEXT_ADDR_OFFSET),
  parameter logic [DATA_W-1:0] LOCK_ADDR        = '0,
  parameter logic [DATA_W-1:0] LOCK_ID          = DATA_W'(1),
  parameter logic [DATA_W-1:0] EMPTY_KEY        = DATA_W'(DEFAULT_EMPTY_KEY),
  parameter int                BACKOFF_MAX_LOG2 = 4,
  parameter int                MAX_LOCK_TRIES   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_val_i,
  output logic              core_req_rdy_o,
  input  logic [2:0]        core_req_op_i,
  input  logic [DATA_W-1:0] core_req_addr_i,
  input  logic [DATA_W-1:0] core_req_size_i,
  input  logic [DATA_W-1:0] core_req_next_addr_i,
  output logic              core_rsp_val_o,
  input  logic              core_rsp_rdy_i,
  output logic [DATA_W-1:0] core_rsp_addr_o,
  output logic [DATA_W-1:0] core_rsp_size_o,
  output logic [DATA_W-1:0] core_rsp_next_addr_o,
  output logic              core_rsp_err_o,
  output logic              mem_req_val_o,
  input  logic              mem_req_rdy_i,
  output logic              mem_req_is_write_o,
  output logic              mem_req_is_cas_o,
  output logic [DATA_W-1:0] mem_req_addr_o,
  output logic [DATA_W-1:0] mem_req_data_o,
  output logic [DATA_W-1:0] mem_req_cas_exp_o,
  input  logic              mem_rsp_val_i,
  output logic              mem_rsp_rdy_o,
  input  logic [DATA_W-1:0] mem_rsp_data_i
);

  falafel_state_e  state;
  falafel_state_e  state_next;
  falafel_state_e  phase;
  falafel_lsu_op_e op_q;
  falafel_lsu_op_e req_op;

  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] size_q;
  logic [DATA_W-1:0] next_q;
  logic [DATA_W-1:0] rsp_size_q;
  logic [DATA_W-1:0] rsp_next_q;
  logic [DATA_W-1:0] next_word_addr;
  logic              err_q;

  logic accept;
  logic mem_fire;
  logic mem_take;
  logic fail;
  logic give_up;
  logic backoff_done;

  assign req_op         = falafel_lsu_op_e'(core_req_op_i);
  assign next_word_addr = addr_q + NEXT_ADDR_OFFSET;

  assign core_rsp_addr_o      = addr_q;
  assign core_rsp_size_o      = rsp_size_q;
  assign core_rsp_next_addr_o = rsp_next_q;
  assign core_rsp_err_o       = err_q;

  falafel_lock_backoff #(
    .BACKOFF_MAX_LOG2 (BACKOFF_MAX_LOG2),
    .MAX_LOCK_TRIES   (MAX_LOCK_TRIES)
  ) u_backoff (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (accept),
    .fail    (fail),
    .done    (backoff_done),
    .give_up (give_up)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next         = state;
    core_req_rdy_o     = 1'b0;
    core_rsp_val_o     = 1'b0;
    mem_req_val_o      = 1'b0;
    mem_req_is_write_o = 1'b0;
    mem_req_is_cas_o   = 1'b0;
    mem_req_addr_o     = '0;
    mem_req_data_o     = '0;
    mem_req_cas_exp_o  = '0;
    mem_rsp_rdy_o      = 1'b0;
    accept             = 1'b0;
    mem_take           = 1'b0;
    fail               = 1'b0;

    case (state)
      ST_IDLE: begin
        // Ready is masked during reset so every output reads 0 while rst_i is high.
        core_req_rdy_o = !rst_i;
        accept         = core_req_val_i && !rst_i;
        if (accept) begin
          state_next = first_state(req_op);
        end
      end
      ST_LK_LOAD: begin
        mem_req_val_o  = 1'b1;
        mem_req_addr_o = LOCK_ADDR;
      end
      ST_LK_CAS: begin
        mem_req_val_o     = 1'b1;
        mem_req_is_cas_o  = 1'b1;
        mem_req_addr_o    = LOCK_ADDR;
        mem_req_data_o    = LOCK_ID;
        mem_req_cas_exp_o = EMPTY_KEY;
      end
      ST_ACC_SIZE: begin
        mem_req_val_o = 1'b1;
        case (op_q)
          OP_LOAD: begin
            mem_req_addr_o = addr_q;
          end
          OP_UNLOCK: begin
            mem_req_is_write_o = 1'b1;
            mem_req_addr_o     = LOCK_ADDR;
            mem_req_data_o     = EMPTY_KEY;
          end
          default: begin
            mem_req_is_write_o = 1'b1;
            mem_req_addr_o     = addr_q;
            mem_req_data_o     = size_q;
          end
        endcase
      end
      ST_ACC_NEXT: begin
        mem_req_val_o      = 1'b1;
        mem_req_addr_o     = next_word_addr;
        mem_req_is_write_o = (op_q != OP_LOAD);
        mem_req_data_o     = (op_q != OP_LOAD) ? next_q : '0;
      end
      ST_WAIT: begin
        mem_rsp_rdy_o = 1'b1;
        mem_take      = mem_rsp_val_i;
        if (mem_take) begin
          case (phase)
            ST_LK_LOAD: begin
              if (mem_rsp_data_i == EMPTY_KEY) state_next = ST_LK_CAS;
              else                             fail       = 1'b1;
            end
            ST_LK_CAS: begin
              if (mem_rsp_data_i == EMPTY_KEY) state_next = ST_RSP;
              else                             fail       = 1'b1;
            end
            ST_ACC_SIZE: state_next = (op_q == OP_UNLOCK) ? ST_RSP : ST_ACC_NEXT;
            default:     state_next = ST_RSP;
          endcase
          if (fail) begin
            state_next = give_up ? ST_RSP : ST_BACKOFF;
          end
        end
      end
      ST_BACKOFF: begin
        if (backoff_done) begin
          state_next = ST_LK_LOAD;
        end
      end
      ST_RSP: begin
        core_rsp_val_o = 1'b1;
        if (core_rsp_rdy_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    mem_fire = mem_req_val_o && mem_req_rdy_i;
    if (mem_fire) begin
      state_next = ST_WAIT;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q       <= OP_LOCK;
      phase      <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      next_q     <= '0;
      rsp_size_q <= '0;
      rsp_next_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= req_op;
        addr_q     <= core_req_addr_i;
        size_q     <= core_req_size_i;
        next_q     <= core_req_next_addr_i;
        rsp_size_q <= '0;
        rsp_next_q <= '0;
        err_q      <= (req_op == OP_ILLEGAL);
      end
      // Remember which access is in flight so WAIT knows where to resume.
      if (mem_fire) begin
        phase <= state;
      end
      if (mem_take && (op_q == OP_LOAD)) begin
        if (phase == ST_ACC_SIZE) rsp_size_q <= mem_rsp_data_i;
        if (phase == ST_ACC_NEXT) rsp_next_q <= mem_rsp_data_i;
      end
      if (give_up) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_falafel_hdr_lsu.sv
`default_nettype none
// tb_falafel_hdr_lsu: directed vector table plus hand sequences for stalls, lock contention and reset.
module tb_falafel_hdr_lsu;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         core_req_val = 1'b0;
  logic         core_req_rdy_o;
  logic [2:0]   core_req_op = '0;
  logic [W-1:0] core_req_addr = '0;
  logic [W-1:0] core_req_size = '0;
  logic [W-1:0] core_req_next = '0;
  logic         core_rsp_val_o;
  logic         core_rsp_rdy = 1'b0;
  logic [W-1:0] core_rsp_addr_o;
  logic [W-1:0] core_rsp_size_o;
  logic [W-1:0] core_rsp_next_addr_o;
  logic         core_rsp_err_o;
  logic         mem_req_val_o;
  logic         mem_req_rdy = 1'b1;
  logic         mem_req_is_write_o;
  logic         mem_req_is_cas_o;
  logic [W-1:0] mem_req_addr_o;
  logic [W-1:0] mem_req_data_o;
  logic [W-1:0] mem_req_cas_exp_o;
  logic         mem_rsp_val = 1'b0;
  logic         mem_rsp_rdy_o;
  logic [W-1:0] mem_rsp_data = '0;

  falafel_hdr_lsu #(
    .DATA_W         (W),
    .MAX_LOCK_TRIES (3)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .core_req_val_i       (core_req_val),
    .core_req_rdy_o       (core_req_rdy_o),
    .core_req_op_i        (core_req_op),
    .core_req_addr_i      (core_req_addr),
    .core_req_size_i      (core_req_size),
    .core_req_next_addr_i (core_req_next),
    .core_rsp_val_o       (core_rsp_val_o),
    .core_rsp_rdy_i       (core_rsp_rdy),
    .core_rsp_addr_o      (core_rsp_addr_o),
    .core_rsp_size_o      (core_rsp_size_o),
    .core_rsp_next_addr_o (core_rsp_next_addr_o),
    .core_rsp_err_o       (core_rsp_err_o),
    .mem_req_val_o        (mem_req_val_o),
    .mem_req_rdy_i        (mem_req_rdy),
    .mem_req_is_write_o   (mem_req_is_write_o),
    .mem_req_is_cas_o     (mem_req_is_cas_o),
    .mem_req_addr_o       (mem_req_addr_o),
    .mem_req_data_o       (mem_req_data_o),
    .mem_req_cas_exp_o    (mem_req_cas_exp_o),
    .mem_rsp_val_i        (mem_rsp_val),
    .mem_rsp_rdy_o        (mem_rsp_rdy_o),
    .mem_rsp_data_i       (mem_rsp_data)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic         wr;
    logic         cas;
    logic [W-1:0] addr;
    logic [W-1:0] data;
    logic [W-1:0] exp;
    int           cyc;
  } tx_t;

  tx_t          log_q[$];
  logic [W-1:0] rd_q[$];
  int           stall_cycles = 0;
  bit           hold_rsp = 1'b0;

  initial begin
    bit           fire_prev = 1'b0;
    bit           cons_prev = 1'b0;
    int           stall_cnt = 0;
    logic [W-1:0] pend_data = '0;
    tx_t          snap;
    tx_t          t;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mem_rsp_val = 1'b0;
        mem_req_rdy = 1'b1;
        fire_prev   = 1'b0;
        cons_prev   = 1'b0;
        stall_cnt   = 0;
      end else begin
        if (cons_prev) mem_rsp_val = 1'b0;
        if (fire_prev && !hold_rsp) begin
          mem_rsp_val  = 1'b1;
          mem_rsp_data = pend_data;
        end
        if (mem_req_val_o) begin
          if (stall_cnt == 0) begin
            snap.wr = mem_req_is_write_o; snap.cas = mem_req_is_cas_o;
            snap.addr = mem_req_addr_o;   snap.data = mem_req_data_o;
          end else begin
            chk("mem_req_addr_stable", mem_req_addr_o, snap.addr);
            chk("mem_req_data_stable", mem_req_data_o, snap.data);
            chk("mem_req_ctrl_stable", {62'd0, mem_req_is_write_o, mem_req_is_cas_o}, {62'd0, snap.wr, snap.cas});
          end
          if (stall_cnt < stall_cycles) begin
            mem_req_rdy = 1'b0;
            stall_cnt++;
          end else begin
            mem_req_rdy = 1'b1;
            stall_cnt   = 0;
          end
        end else begin
          mem_req_rdy = 1'b1;
        end
        fire_prev = mem_req_val_o && mem_req_rdy;
        if (fire_prev) begin
          t.wr = mem_req_is_write_o; t.cas = mem_req_is_cas_o;
          t.addr = mem_req_addr_o;   t.data = mem_req_data_o;
          t.exp = mem_req_cas_exp_o; t.cyc = cyc;
          log_q.push_back(t);
          pend_data = '0;
          if (!mem_req_is_write_o && rd_q.size() > 0) pend_data = rd_q.pop_front();
        end
        cons_prev = mem_rsp_val && mem_rsp_rdy_o;
      end
    end
  end

  // ---------------- core driver ----------------
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] addr, input logic [W-1:0] size,
                        input logic [W-1:0] nxt, input int rsp_delay,
                        output logic [W-1:0] r_addr, output logic [W-1:0] r_size,
                        output logic [W-1:0] r_next, output logic r_err, output int lat);
    int n;
    int t0;
    r_addr = '0; r_size = '0; r_next = '0; r_err = 1'b0; lat = -1;
    core_req_op = op; core_req_addr = addr; core_req_size = size; core_req_next = nxt;
    core_req_val = 1'b1;
    n = 0;
    while (!core_req_rdy_o && n < 100) begin @(posedge clk); #1; n++; end
    if (!core_req_rdy_o) begin
      core_req_val = 1'b0;
      chk("req_accept_timeout", 64'd0, 64'd1);
      return;
    end
    t0 = cyc;
    @(posedge clk); #1;
    core_req_val = 1'b0;
    n = 0;
    while (!core_rsp_val_o && n < 500) begin @(posedge clk); #1; n++; end
    if (!core_rsp_val_o) begin
      chk("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    lat = cyc - t0;
    r_addr = core_rsp_addr_o; r_size = core_rsp_size_o;
    r_next = core_rsp_next_addr_o; r_err = core_rsp_err_o;
    for (int k = 0; k < rsp_delay; k++) begin
      @(posedge clk); #1;
      chk("rsp_val_held", 64'(core_rsp_val_o), 64'd1);
      chk("rsp_size_held", core_rsp_size_o, r_size);
      chk("rsp_next_held", core_rsp_next_addr_o, r_next);
    end
    core_rsp_rdy = 1'b1;
    @(posedge clk); #1;
    core_rsp_rdy = 1'b0;
  endtask

  task automatic chk_tx(input string p, input tx_t t, input logic w, input logic c,
                        input logic [W-1:0] a, input logic [W-1:0] d);
    chk({p, "_is_cas"}, 64'(t.cas), 64'(c));
    if (!c) chk({p, "_is_write"}, 64'(t.wr), 64'(w));
    chk({p, "_addr"}, t.addr, a);
    if (w || c) chk({p, "_data"}, t.data, d);
    if (c) chk({p, "_cas_exp"}, t.exp, 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] addr, size, nxt, rd0, rd1;
    int           ntx;
    logic         w0, c0; logic [W-1:0] a0, d0;
    logic         w1, c1; logic [W-1:0] a1, d1;
    logic [W-1:0] rsz, rnx;
    logic         rerr;
    int           lat;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  logic [W-1:0] ra, rs, rn;
  logic         re;
  int           lat;
  logic [W-1:0] all_zero_probe;

  initial begin
    // LOAD
    vecs[0] = '{3'd2, 64'h1000, 64'h0, 64'h0, 64'h40, 64'h2000, 2,
                1'b0, 1'b0, 64'h1000, 64'h0, 1'b0, 1'b0, 64'h1008, 64'h0, 64'h40, 64'h2000, 1'b0, 5};
    // UNLOCK
    vecs[1] = '{3'd1, 64'h55, 64'h0, 64'h0, 64'h0, 64'h0, 1,
                1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 3};
    // ALLOC_INSERT
    vecs[2] = '{3'd4, 64'h2000, 64'h20, 64'h5000, 64'h0, 64'h0, 2,
                1'b1, 1'b0, 64'h2000, 64'h20, 1'b1, 1'b0, 64'h2008, 64'h5000, 64'h0, 64'h0, 1'b0, 5};
    // FREE_INSERT with wrapping next_addr word address
    vecs[3] = '{3'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h99, 64'h7777, 64'h0, 64'h0, 1,
                1'b1, 1'b0, 64'h4, 64'h7777, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 3};
    // DELETE
    vecs[4] = '{3'd6, 64'h3000, 64'hAAAA, 64'h0, 64'h0, 64'h0, 1,
                1'b1, 1'b0, 64'h3008, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 3};
    // illegal op 7
    vecs[5] = '{3'd7, 64'h123, 64'h0, 64'h0, 64'h0, 64'h0, 0,
                1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1};
    // uncontended LOCK
    vecs[6] = '{3'd0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 2,
                1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 64'h1, 64'h0, 64'h0, 1'b0, 5};
    // LOAD whose second word wraps to 0
    vecs[7] = '{3'd2, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 64'h11, 64'h22, 2,
                1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h11, 64'h22, 1'b0, 5};

    #1;
    all_zero_probe = 64'(|{core_req_rdy_o, core_rsp_val_o, core_rsp_addr_o, core_rsp_size_o,
                           core_rsp_next_addr_o, core_rsp_err_o, mem_req_val_o, mem_req_is_write_o,
                           mem_req_is_cas_o, mem_req_addr_o, mem_req_data_o, mem_req_cas_exp_o, mem_rsp_rdy_o});
    chk("reset_outputs_zero", all_zero_probe, 64'd0);
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_req_rdy", 64'(core_req_rdy_o), 64'd1);

    for (int i = 0; i < NV; i++) begin
      log_q.delete(); rd_q.delete();
      rd_q.push_back(vecs[i].rd0); rd_q.push_back(vecs[i].rd1);
      run_op(vecs[i].op, vecs[i].addr, vecs[i].size, vecs[i].nxt, 0, ra, rs, rn, re, lat);
      chk($sformatf("v%0d_ntx", i), 64'(log_q.size()), 64'(vecs[i].ntx));
      chk($sformatf("v%0d_rsp_addr", i), ra, vecs[i].addr);
      chk($sformatf("v%0d_rsp_size", i), rs, vecs[i].rsz);
      chk($sformatf("v%0d_rsp_next", i), rn, vecs[i].rnx);
      chk($sformatf("v%0d_rsp_err", i), 64'(re), 64'(vecs[i].rerr));
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      if (vecs[i].ntx >= 1 && log_q.size() >= 1)
        chk_tx($sformatf("v%0d_tx0", i), log_q[0], vecs[i].w0, vecs[i].c0, vecs[i].a0, vecs[i].d0);
      if (vecs[i].ntx >= 2 && log_q.size() >= 2)
        chk_tx($sformatf("v%0d_tx1", i), log_q[1], vecs[i].w1, vecs[i].c1, vecs[i].a1, vecs[i].d1);
    end

    // UPDATE with 3-cycle memory stalls per request and a delayed response accept.
    log_q.delete(); rd_q.delete();
    stall_cycles = 3;
    run_op(3'd3, 64'h1000, 64'h80, 64'h3000, 2, ra, rs, rn, re, lat);
    stall_cycles = 0;
    chk("upd_ntx", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk_tx("upd_tx0", log_q[0], 1'b1, 1'b0, 64'h1000, 64'h80);
      chk_tx("upd_tx1", log_q[1], 1'b1, 1'b0, 64'h1008, 64'h3000);
    end
    chk("upd_err", 64'(re), 64'd0);
    chk("upd_latency", 64'(lat), 64'd11);

    // Contended LOCK: busy, busy, free, CAS succeeds.
    log_q.delete(); rd_q.delete();
    rd_q.push_back(64'h1); rd_q.push_back(64'h1); rd_q.push_back(64'h0); rd_q.push_back(64'h0);
    run_op(3'd0, 64'h0, 64'h0, 64'h0, 0, ra, rs, rn, re, lat);
    chk("lk_err", 64'(re), 64'd0);
    chk("lk_ntx", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      chk("lk_backoff_gap1", 64'(log_q[1].cyc - log_q[0].cyc - 2), 64'd1);
      chk("lk_backoff_gap2", 64'(log_q[2].cyc - log_q[1].cyc - 2), 64'd2);
      chk("lk_cas_no_gap", 64'(log_q[3].cyc - log_q[2].cyc - 2), 64'd0);
      for (int k = 0; k < 3; k++) chk_tx($sformatf("lk_load%0d", k), log_q[k], 1'b0, 1'b0, 64'h0, 64'h0);
      chk_tx("lk_cas", log_q[3], 1'b0, 1'b1, 64'h0, 64'h1);
    end

    // LOCK that never sees a free word: gives up after 3 tries.
    log_q.delete(); rd_q.delete();
    for (int k = 0; k < 5; k++) rd_q.push_back(64'h1);
    run_op(3'd0, 64'h0, 64'h0, 64'h0, 0, ra, rs, rn, re, lat);
    chk("giveup_err", 64'(re), 64'd1);
    chk("giveup_ntx", 64'(log_q.size()), 64'd3);
    foreach (log_q[k]) chk($sformatf("giveup_load%0d_cas", k), 64'(log_q[k].cas), 64'd0);

    // Reset while waiting for a memory response.
    log_q.delete(); rd_q.delete();
    hold_rsp = 1'b1;
    core_req_op = 3'd2; core_req_addr = 64'h1000; core_req_val = 1'b1;
    begin
      int n = 0;
      while (!core_req_rdy_o && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      core_req_val = 1'b0;
      n = 0;
      while (!mem_rsp_rdy_o && n < 50) begin @(posedge clk); #1; n++; end
      chk("rst_reached_wait", 64'(mem_rsp_rdy_o), 64'd1);
    end
    rst = 1'b1;
    #1;
    all_zero_probe = 64'(|{core_req_rdy_o, core_rsp_val_o, core_rsp_addr_o, core_rsp_size_o,
                           core_rsp_next_addr_o, core_rsp_err_o, mem_req_val_o, mem_req_is_write_o,
                           mem_req_is_cas_o, mem_req_addr_o, mem_req_data_o, mem_req_cas_exp_o, mem_rsp_rdy_o});
    chk("midtx_reset_outputs_zero", all_zero_probe, 64'd0);
    begin
      bit seen_rsp = 1'b0;
      repeat (2) begin @(posedge clk); #1; if (core_rsp_val_o) seen_rsp = 1'b1; end
      rst = 1'b0;
      hold_rsp = 1'b0;
      repeat (4) begin @(posedge clk); #1; if (core_rsp_val_o) seen_rsp = 1'b1; end
      chk("no_rsp_for_abandoned_req", 64'(seen_rsp), 64'd0);
    end
    log_q.delete(); rd_q.delete();
    rd_q.push_back(64'h40); rd_q.push_back(64'h2000);
    run_op(3'd2, 64'h1000, 64'h0, 64'h0, 0, ra, rs, rn, re, lat);
    chk("post_rst_size", rs, 64'h40);
    chk("post_rst_next", rn, 64'h2000);
    chk("post_rst_err", 64'(re), 64'd0);
    chk("post_rst_latency", 64'(lat), 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
